// File: rtl/spi_initiator_core.sv
// SPI initiator: shifts valid/ready TX words out on SCK/MOSI in any CPOL/CPHA mode and
// assembles MISO into an RX word; a chip select can be held across words for bursts.
module spi_initiator_core #(
  parameter int DAT_WIDTH = 8,
  parameter int NUM_CS    = 4,
  parameter int DIV_WIDTH = 8,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_cpol_i,
  input  logic                 cfg_cpha_i,
  input  logic [CS_W-1:0]      cfg_cs_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DAT_WIDTH-1:0] tx_data_i,
  input  logic                 tx_last_i,
  output logic                 rx_valid_o,
  output logic [DAT_WIDTH-1:0] rx_data_o,
  output logic                 busy_o,
  output logic                 sck_o,
  output logic                 mosi_o,
  input  logic                 miso_i,
  output logic [NUM_CS-1:0]    csn_o
);

  localparam int EDGE_W = $clog2(2 * DAT_WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DAT_WIDTH);
  localparam logic [EDGE_W-1:0] PEN_EDGE  = EDGE_W'(2 * DAT_WIDTH - 1);

  // state | meaning
  // IDLE  | ready for a word, SCK parked at CPOL
  // SETUP | one half-period lead-in after CS falls
  // XFER  | 2*DAT_WIDTH half-periods, SCK toggles at each boundary
  // HOLD  | one half-period tail, then RX word is published
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_cpol;
  logic                 r_cpha;
  logic                 r_last;
  logic                 r_cs_held;
  logic [CS_W-1:0]      r_cs;
  logic [EDGE_W-1:0]    r_edge;
  logic [DAT_WIDTH-1:0] r_tx_sh;
  logic [DAT_WIDTH-1:0] r_rx_sh;
  logic [DAT_WIDTH-1:0] r_rx_data;
  logic                 r_sample;
  logic                 r_sck;
  logic                 r_mosi;
  logic                 r_rx_valid;
  logic                 r_tx_ready;
  logic [NUM_CS-1:0]    r_csn;

  logic [CS_W-1:0]      w_cs_sel;
  logic                 w_accept;
  logic                 w_tc;
  logic [EDGE_W-1:0]    w_edge_nxt;
  logic                 w_lead;

  assign w_cs_sel   = r_cs_held ? r_cs : cfg_cs_i;
  assign w_accept   = tx_valid_i && r_tx_ready;
  assign w_tc       = (r_cnt == '0);
  assign w_edge_nxt = r_edge + 1'b1;
  // odd-numbered toggles move SCK away from CPOL
  assign w_lead     = w_edge_nxt[0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_cnt      <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_last     <= 1'b0;
      r_cs_held  <= 1'b0;
      r_cs       <= '0;
      r_edge     <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_sample   <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_csn      <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      r_sample   <= 1'b0;
      // capture is one cycle after the sampling toggle, i.e. while SCK shows the new level
      if (r_sample) r_rx_sh <= {r_rx_sh[DAT_WIDTH-2:0], miso_i};
      case (r_state)
        S_IDLE: begin
          r_tx_ready <= 1'b1;
          if (w_accept) begin
            r_tx_ready <= 1'b0;
            r_div      <= cfg_div_i;
            r_cnt      <= cfg_div_i;
            r_cpol     <= cfg_cpol_i;
            r_cpha     <= cfg_cpha_i;
            r_last     <= tx_last_i;
            r_cs       <= w_cs_sel;
            r_csn      <= ~(NUM_CS'(1) << w_cs_sel);
            r_sck      <= cfg_cpol_i;
            r_tx_sh    <= tx_data_i;
            r_edge     <= '0;
            if (!cfg_cpha_i) r_mosi <= tx_data_i[DAT_WIDTH-1];
            r_state    <= S_SETUP;
          end
        end
        S_SETUP, S_XFER: begin
          if (!w_tc) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt <= r_div;
            if (r_edge == LAST_EDGE) begin
              r_state <= S_HOLD;
            end else begin
              r_state  <= S_XFER;
              r_sck    <= ~r_sck;
              r_edge   <= w_edge_nxt;
              r_sample <= w_lead ^ r_cpha;
              if (r_cpha && w_lead) begin
                r_mosi  <= r_tx_sh[DAT_WIDTH-1];
                r_tx_sh <= r_tx_sh << 1;
              end else if (!r_cpha && !w_lead && (r_edge != PEN_EDGE)) begin
                r_mosi  <= r_tx_sh[DAT_WIDTH-2];
                r_tx_sh <= r_tx_sh << 1;
              end
            end
          end
        end
        S_HOLD: begin
          if (!w_tc) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_sh;
            r_cs_held  <= !r_last;
            if (r_last) r_csn <= '1;
            r_tx_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ready_o = r_tx_ready;
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign busy_o     = (r_state != S_IDLE);
  assign sck_o      = r_sck;
  assign mosi_o     = r_mosi;
  assign csn_o      = r_csn;

endmodule

// File: tb/tb_spi_initiator_core.sv
// Bench for spi_initiator_core: randomised words, an edge-driven SPI target model and a
// scoreboard that checks every RX pulse, its latency, and the chip-select pattern each cycle.
module tb_spi_initiator_core;
  localparam int W   = 8;
  localparam int NCS = 4;
  localparam int DW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  cfg_div = '0;
  logic           cfg_cpol = 1'b0;
  logic           cfg_cpha = 1'b0;
  logic [1:0]     cfg_cs = '0;
  logic           tx_valid = 1'b0;
  logic [W-1:0]   tx_data = '0;
  logic           tx_last = 1'b1;
  logic           tx_ready;
  logic           rx_valid;
  logic [W-1:0]   rx_data;
  logic           busy;
  logic           sck;
  logic           mosi;
  logic           miso;
  logic [NCS-1:0] csn;

  int   mode = 1;        // 0: target model, 1: loopback, 2: constant one
  logic tgt_miso = 1'b0;
  assign miso = (mode == 1) ? mosi : (mode == 2) ? 1'b1 : tgt_miso;

  spi_initiator_core #(.DAT_WIDTH(W), .NUM_CS(NCS), .DIV_WIDTH(DW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .cfg_div_i(cfg_div), .cfg_cpol_i(cfg_cpol),
    .cfg_cpha_i(cfg_cpha), .cfg_cs_i(cfg_cs), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_data_i(tx_data), .tx_last_i(tx_last), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .busy_o(busy), .sck_o(sck), .mosi_o(mosi), .miso_i(miso), .csn_o(csn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_rx;
    int         acc;
    int         div;
    logic       cpol;
    logic       cpha;
    logic       last;
    int         cs;
  } item_t;

  item_t      sb_q[$];
  logic [7:0] tgt_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  logic held = 1'b0;
  int   held_cs = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Called on a negedge where tx_ready is high: the next posedge accepts this word.
  task automatic issue(input logic [7:0] d, input int dv, input logic pol, input logic pha,
                       input int cs, input logic lst);
    item_t it;
    logic [7:0] w;
    cfg_div  = 8'(dv);
    cfg_cpol = pol;
    cfg_cpha = pha;
    cfg_cs   = 2'(cs);
    tx_data  = d;
    tx_last  = lst;
    tx_valid = 1'b1;
    it.tx   = d;
    it.acc  = cyc;
    it.div  = dv;
    it.cpol = pol;
    it.cpha = pha;
    it.last = lst;
    it.cs   = held ? held_cs : cs;
    held_cs = it.cs;
    held    = !lst;
    if (mode == 0) begin
      w = 8'($urandom);
      tgt_q.push_back(w);
      it.exp_rx = w;
    end else if (mode == 1) begin
      it.exp_rx = d;
    end else begin
      it.exp_rx = 8'hFF;
    end
    sb_q.push_back(it);
  endtask

  task automatic send_word(input logic [7:0] d, input int dv, input logic pol, input logic pha,
                           input int cs, input logic lst);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      chk("ready_timeout", 32'(tx_ready), 32'd1);
    end else begin
      issue(d, dv, pol, pha, cs, lst);
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      cfg_cs   = 2'($urandom);
      cfg_cpol = 1'($urandom);
      cfg_div  = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor and SPI target model
  item_t      it_m;
  item_t      cur;
  int         edges = 0;
  int         t_idx = 0;
  logic [7:0] t_rx = '0;
  logic [7:0] t_word = '0;
  logic [3:0] exp_csn = 4'hF;
  logic [3:0] one4 = 4'b0001;
  logic       prev_busy = 1'b0;
  logic       prev_sck = 1'b0;
  logic       lead;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      tgt_q.delete();
      exp_csn   = 4'hF;
      prev_busy = 1'b0;
      prev_sck  = sck;
    end else begin
      if (rx_valid) begin
        rx_cnt++;
        if (sb_q.size() == 0) begin
          chk("rx_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          it_m = sb_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(it_m.exp_rx));
          chk("rx_latency", cyc - it_m.acc, 1 + (2 * W + 2) * (it_m.div + 1));
          chk("mosi_word", 32'(t_rx), 32'(it_m.tx));
          chk("sck_edges", edges, 2 * W);
          chk("sck_idle", 32'(sck), 32'(it_m.cpol));
          if (it_m.last) exp_csn = 4'hF;
        end
      end
      if (busy && !prev_busy) begin
        if (sb_q.size() == 0) begin
          chk("busy_unexpected", 32'(busy), 32'd0);
        end else begin
          cur     = sb_q[0];
          exp_csn = ~(one4 << cur.cs);
          edges   = 0;
          t_rx    = '0;
          t_word  = '0;
          if (tgt_q.size() != 0) t_word = tgt_q.pop_front();
          if (cur.cpha) begin
            t_idx = 7;
          end else begin
            tgt_miso = t_word[7];
            t_idx    = 6;
          end
        end
      end else if (busy && prev_busy && (sck !== prev_sck)) begin
        edges++;
        lead = (sck != cur.cpol);
        if (lead ^ cur.cpha) begin
          t_rx = {t_rx[6:0], mosi};
        end else if (t_idx >= 0) begin
          tgt_miso = t_word[t_idx];
          t_idx--;
        end
      end
      chk("csn", 32'(csn), 32'(exp_csn));
      prev_busy = busy;
      prev_sck  = sck;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int acc6;
  int rxb;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_csn", 32'(csn), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // loopback, mode 0, div 0, cs 2
    mode = 1;
    send_word(8'hA5, 0, 1'b0, 1'b0, 2, 1'b1);
    drain();

    // loopback in modes 1..3, div 3
    for (int m = 1; m < 4; m++) send_word(8'h3C, 3, 1'(m >> 1), 1'(m & 1), 0, 1'b1);
    drain();

    // burst on one target while cfg_cs wanders
    mode = 0;
    send_word(8'h01, 2, 1'b0, 1'b0, 1, 1'b0);
    send_word(8'h80, 2, 1'b0, 1'b0, 3, 1'b0);
    send_word(8'hFF, 2, 1'b0, 1'b0, 0, 1'b1);
    drain();

    // constant-one target, maximum divider
    mode = 2;
    send_word(8'h96, 255, 1'b0, 1'b1, 3, 1'b1);
    drain();

    // reset in the middle of a word, then a clean word
    mode = 1;
    send_word(8'h5A, 3, 1'b0, 1'b1, 1, 1'b1);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_csn", 32'(csn), 32'hF);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_tx_ready", 32'(tx_ready), 32'd0);
    held = 1'b0;
    held_cs = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'hC3, 1, 1'b1, 1'b1, 2, 1'b1);
    drain();

    // tx_valid held high with changing data: only accepted words are expected
    mode = 0;
    acc6 = 0;
    rxb  = rx_cnt;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      cfg_cpol = 1'($urandom);
      cfg_cpha = 1'($urandom);
      cfg_cs   = 2'($urandom);
      if (tx_ready) begin
        issue(tx_data, 1, cfg_cpol, cfg_cpha, int'(cfg_cs), 1'b1);
        acc6++;
      end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    drain();
    chk("rx_count_vs_accepts", rx_cnt - rxb, acc6);

    // random words, modes, dividers, targets and bursts
    for (int i = 0; i < 24; i++)
      send_word(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                (i == 23) ? 1'b1 : 1'($urandom_range(0, 1)));
    drain();
    repeat (2) @(negedge clk);
    chk("final_csn", 32'(csn), 32'hF);
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
